// File: rtl/clkdiv_pkg.sv
// Shared constants and helpers for the programmable clock divider.
//
// Contents:
//   CLKDIV_MIN_RATIO        smallest legal division ratio
//   CLKDIV_CNT_WIDTH_DEF    default counter/ratio width
//   CLKDIV_DIV_DEFAULT_DEF  default ratio active after reset
//   clkdiv_clamp()          maps a requested ratio onto the legal range
//                           (values below CLKDIV_MIN_RATIO become CLKDIV_MIN_RATIO)
//
// The clamp works on 32-bit values, so ratio widths up to 32 bits are supported.
package clkdiv_pkg;

  localparam int CLKDIV_MIN_RATIO       = 2;
  localparam int CLKDIV_CNT_WIDTH_DEF   = 16;
  localparam int CLKDIV_DIV_DEFAULT_DEF = 4096;

  function automatic logic [31:0] clkdiv_clamp(input logic [31:0] value);
    logic [31:0] result;
    result = value;
    if (value < 32'(CLKDIV_MIN_RATIO)) begin
      result = 32'(CLKDIV_MIN_RATIO);
    end
    return result;
  endfunction

endpackage

// File: rtl/clkdiv_ratio_reg.sv
// Ratio bookkeeping for the programmable clock divider.
//
// Holds the active ratio, a pending ratio captured by a load strobe, and the
// pending flag. A pending ratio is promoted to active either at a period wrap
// that happens after the capture edge, or on any edge with the divider
// disabled. With the divider disabled a load goes straight to the active ratio.
//
// Ports:
//   i_clock    in   1          system clock
//   i_reset_n  in   1          asynchronous reset, active low
//   i_load     in   1          capture strobe for i_value
//   i_value    in   CNT_WIDTH  requested ratio (clamped before storing)
//   i_wrap     in   1          counter is in the last cycle of its period
//   i_enable   in   1          divider running
//   o_active   out  CNT_WIDTH  ratio currently used by the counter
//   o_pending  out  1          a captured ratio is waiting for promotion
module clkdiv_ratio_reg
  import clkdiv_pkg::*;
#(
  parameter int CNT_WIDTH   = CLKDIV_CNT_WIDTH_DEF,
  parameter int DIV_DEFAULT = CLKDIV_DIV_DEFAULT_DEF
) (
  input  logic                 i_clock,
  input  logic                 i_reset_n,
  input  logic                 i_load,
  input  logic [CNT_WIDTH-1:0] i_value,
  input  logic                 i_wrap,
  input  logic                 i_enable,
  output logic [CNT_WIDTH-1:0] o_active,
  output logic                 o_pending
);

  logic [CNT_WIDTH-1:0] r_active;
  logic [CNT_WIDTH-1:0] r_pend_val;
  logic                 r_pending;
  logic [CNT_WIDTH-1:0] w_clamped;

  assign w_clamped = CNT_WIDTH'(clkdiv_clamp(32'(i_value)));

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_active   <= CNT_WIDTH'(DIV_DEFAULT);
      r_pend_val <= CNT_WIDTH'(DIV_DEFAULT);
      r_pending  <= 1'b0;
    end else if (!i_enable) begin
      // Disabled: the period is being truncated anyway, so a new ratio can
      // take effect right away. A simultaneous load beats an older pending one.
      if (i_load) begin
        r_active <= w_clamped;
      end else if (r_pending) begin
        r_active <= r_pend_val;
      end
      r_pending <= 1'b0;
    end else begin
      // A load on the wrap edge itself is not promoted here: the old pending
      // value (if any) is promoted and the new one waits for the next wrap.
      if (i_wrap && r_pending) begin
        r_active <= r_pend_val;
      end
      if (i_load) begin
        r_pend_val <= w_clamped;
        r_pending  <= 1'b1;
      end else if (i_wrap) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign o_active  = r_active;
  assign o_pending = r_pending;

endmodule

// File: rtl/clock_divider_prog.sv
// Runtime-programmable integer clock divider.
//
// Produces a registered divided clock-enable waveform (clkout, low for
// floor(N/2) cycles then high for ceil(N/2) cycles) and a one-cycle tick in
// the last input cycle of each output period. A new ratio is loaded through
// div_load and only takes effect at a period boundary, so clkout never shows
// runt pulses. clkout is a plain register; any global buffering is left to the
// instantiating level.
//
// Optional feature macro: CLKDIV_PERIOD_CNT_EN adds the 32-bit period_cnt
// output counting completed periods (one per tick, wrapping at 2^32).
//
// Ports:
//   clock        in   1          system clock, all logic on posedge
//   reset_n      in   1          asynchronous reset, active low
//   enable       in   1          1 = run; 0 = counter held at 0, clkout low
//   div_value    in   CNT_WIDTH  requested ratio, sampled when div_load=1
//   div_load     in   1          capture strobe for div_value
//   div_pending  out  1          captured ratio waits for a period boundary
//   clkout       out  1          divided output, registered
//   tick         out  1          one-cycle pulse in the last cycle of a period
//   period_cnt   out  32         completed periods (CLKDIV_PERIOD_CNT_EN only)
module clock_divider_prog
  import clkdiv_pkg::*;
#(
  parameter int CNT_WIDTH   = CLKDIV_CNT_WIDTH_DEF,
  parameter int DIV_DEFAULT = CLKDIV_DIV_DEFAULT_DEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic [CNT_WIDTH-1:0] div_value,
  input  logic                 div_load,
  output logic                 div_pending,
  output logic                 clkout,
  output logic                 tick
`ifdef CLKDIV_PERIOD_CNT_EN
  ,
  output logic [31:0]          period_cnt
`endif
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_count;
  logic                 r_clkout;
  logic                 r_tick;

  logic [CNT_WIDTH-1:0] w_active;
  logic [CNT_WIDTH-1:0] w_half;
  logic                 w_pending;
  logic                 w_wrap;
  logic [CNT_WIDTH-1:0] w_count_next;
  logic                 w_clkout_next;
  logic                 w_tick_next;

  clkdiv_ratio_reg #(
    .CNT_WIDTH  (CNT_WIDTH),
    .DIV_DEFAULT(DIV_DEFAULT)
  ) u_ratio_reg (
    .i_clock  (clock),
    .i_reset_n(reset_n),
    .i_load   (div_load),
    .i_value  (div_value),
    .i_wrap   (w_wrap),
    .i_enable (enable),
    .o_active (w_active),
    .o_pending(w_pending)
  );

  // >= rather than == keeps the counter from running away should it ever be
  // above the ratio; the active ratio only changes while the count is 0.
  assign w_wrap = (r_count >= (w_active - ONE));
  assign w_half = w_active >> 1;

  // clkout and tick are computed from the next count so that, once
  // registered, they line up with the count they describe. The ratio used
  // here is the current one: a newly promoted ratio only matters from count 1
  // onwards, and at count 0 both outputs are low for any legal ratio (N >= 2).
  always_comb begin
    w_count_next  = '0;
    w_clkout_next = 1'b0;
    w_tick_next   = 1'b0;
    if (enable) begin
      if (!w_wrap) begin
        w_count_next = r_count + ONE;
      end
      w_clkout_next = (w_count_next >= w_half);
      w_tick_next   = !w_wrap && (w_count_next == (w_active - ONE));
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count  <= '0;
      r_clkout <= 1'b0;
      r_tick   <= 1'b0;
    end else begin
      r_count  <= w_count_next;
      r_clkout <= w_clkout_next;
      r_tick   <= w_tick_next;
    end
  end

  assign clkout      = r_clkout;
  assign tick        = r_tick;
  assign div_pending = w_pending;

`ifdef CLKDIV_PERIOD_CNT_EN
  logic [31:0] r_period_cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_period_cnt <= '0;
    end else if (r_tick) begin
      r_period_cnt <= r_period_cnt + 32'd1;
    end
  end

  assign period_cnt = r_period_cnt;
`endif

endmodule

// File: tb/tb_clock_divider_prog.sv
// Self-checking bench for clock_divider_prog: a directed vector table, hand
// written multi-cycle scenarios and randomized traffic, all compared each
// cycle against a behavioural model of the divider rules.
module tb_clock_divider_prog;

  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic         clock = 1'b0;
  logic         reset_n = 1'b1;
  logic         enable = 1'b0;
  logic [W-1:0] div_value = '0;
  logic         div_load = 1'b0;
  logic         div_pending;
  logic         clkout;
  logic         tick;
`ifdef CLKDIV_PERIOD_CNT_EN
  logic [31:0]  period_cnt;
`endif

  always #5 clock = ~clock;

  clock_divider_prog #(
    .CNT_WIDTH  (W),
    .DIV_DEFAULT(4096)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .div_value  (div_value),
    .div_load   (div_load),
    .div_pending(div_pending),
    .clkout     (clkout),
    .tick       (tick)
`ifdef CLKDIV_PERIOD_CNT_EN
    ,
    .period_cnt (period_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  int          n_vec = 0;
  int          n_bad = 0;
  string       tag = "init";
  logic [2:0]  exp_q[$];   // {div_pending, clkout, tick}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s.%s: got %0d expected %0d (t=%0t)", tag, name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Position within the current output period, the ratio in force, and the
  // waiting ratio; outputs are derived from the position with plain arithmetic.
  int unsigned m_pos, m_n, m_pend_val;
  bit          m_pend, m_clk, m_tick;
  logic [31:0] m_pcnt;

  function automatic int unsigned clampv(input int unsigned v);
    return (v < 2) ? 2 : v;
  endfunction

  task automatic model_reset();
    m_pos = 0; m_n = 4096; m_pend = 0; m_pend_val = 0;
    m_clk = 0; m_tick = 0; m_pcnt = 0;
  endtask

  task automatic model_edge();
    bit wrap;
    if (m_tick) m_pcnt = m_pcnt + 1;
    if (!enable) begin
      if (div_load) m_n = clampv(int'(div_value));
      else if (m_pend) m_n = m_pend_val;
      m_pend = 0;
      m_pos  = 0;
    end else begin
      wrap = (m_pos == m_n - 1);
      if (wrap) begin
        m_pos = 0;
        if (m_pend) begin
          m_n = m_pend_val;
          m_pend = 0;
        end
      end else begin
        m_pos = m_pos + 1;
      end
      if (div_load) begin
        m_pend_val = clampv(int'(div_value));
        m_pend = 1;
      end
    end
    m_clk  = enable && (m_pos >= m_n / 2);
    m_tick = enable && (m_pos == m_n - 1);
    exp_q.push_back({m_pend, m_clk, m_tick});
  endtask

  // ---------------- driver tasks ----------------
  // One clock: model advances on the edge, DUT checked on the falling edge.
  task automatic step();
    logic [2:0] e;
    @(posedge clock);
    model_edge();
    @(negedge clock);
    e = exp_q.pop_front();
    chk("div_pending", 32'(div_pending), 32'(e[2]));
    chk("clkout", 32'(clkout), 32'(e[1]));
    chk("tick", 32'(tick), 32'(e[0]));
`ifdef CLKDIV_PERIOD_CNT_EN
    chk("period_cnt", period_cnt, m_pcnt);
`endif
  endtask

  task automatic drive(input logic en, input logic ld, input logic [W-1:0] val);
    enable = en; div_load = ld; div_value = val;
    step();
    div_load = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0);
  endtask

  // Runs until div_pending drops; returns the number of cycles or -1.
  task automatic wait_pending_clear(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 5000; i++) begin
      drive(1'b1, 1'b0, '0);
      if (!div_pending) begin
        cycles = i;
        break;
      end
    end
    if (cycles < 0) chk("pending_timeout", 32'(div_pending), 32'd0);
  endtask

  // Distance in cycles between two consecutive ticks, or -1 on timeout.
  task automatic tick_gap(output int gap);
    int first;
    first = -1;
    gap = -1;
    for (int i = 0; i < 10000; i++) begin
      drive(1'b1, 1'b0, '0);
      if (tick) begin
        if (first < 0) first = i;
        else begin
          gap = i - first;
          break;
        end
      end
    end
  endtask

  task automatic apply_reset();
    @(negedge clock);
    #2 reset_n = 1'b0;
    model_reset();
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic         en;
    logic         ld;
    logic [W-1:0] val;
    logic         e_clk;
    logic         e_tick;
    logic         e_pend;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int cyc, gap, highs, ticks, first_tick, first_high;

    tbl[0]  = '{1'b0, 1'b1, 16'd3, 1'b0, 1'b0, 1'b0}; // disabled load: direct
    tbl[1]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 16'd1, 1'b1, 1'b0, 1'b1}; // 1 clamps to 2
    tbl[5]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0}; // N=2 active
    tbl[7]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 16'd6, 1'b0, 1'b0, 1'b1}; // load in wrap cycle
    tbl[9]  = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b1, 1'b1}; // still N=2
    tbl[10] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0}; // N=6 active
    tbl[11] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0}; // truncate
    tbl[13] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 16'd0, 1'b1, 1'b0, 1'b0};

    // ---- reset state ----
    tag = "reset";
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("clkout", 32'(clkout), 32'd0);
    chk("tick", 32'(tick), 32'd0);
    chk("div_pending", 32'(div_pending), 32'd0);
`ifdef CLKDIV_PERIOD_CNT_EN
    chk("period_cnt", period_cnt, 32'd0);
`endif
    @(negedge clock);
    reset_n = 1'b1;

    // ---- vector table ----
    tag = "table";
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].en, tbl[i].ld, tbl[i].val);
      chk($sformatf("row%0d_clk", i), 32'(clkout), 32'(tbl[i].e_clk));
      chk($sformatf("row%0d_tick", i), 32'(tick), 32'(tbl[i].e_tick));
      chk($sformatf("row%0d_pend", i), 32'(div_pending), 32'(tbl[i].e_pend));
    end

    // ---- default ratio 4096 after reset ----
    apply_reset();
    tag = "default";
    highs = 0; ticks = 0; first_tick = -1; first_high = -1;
    for (int i = 1; i <= 8192; i++) begin
      drive(1'b1, 1'b0, '0);
      if (clkout) begin
        highs++;
        if (first_high < 0) first_high = i;
      end
      if (tick) begin
        ticks++;
        if (first_tick < 0) first_tick = i;
      end
    end
    chk("first_high", 32'(first_high), 32'd2048);
    chk("high_cycles", 32'(highs), 32'd4096);
    chk("first_tick", 32'(first_tick), 32'd4095);
    chk("tick_count", 32'(ticks), 32'd2);

    // ---- load N=5 mid-period ----
    tag = "load5";
    run(100);
    drive(1'b1, 1'b1, 16'd5);
    chk("pending_set", 32'(div_pending), 32'd1);
    wait_pending_clear(cyc);
    chk("wait_cycles", 32'(cyc), 32'd3995);
    tick_gap(gap);
    chk("tick_gap", 32'(gap), 32'd5);

    // ---- N=0 and N=1 act as 2 ----
    tag = "load0";
    drive(1'b1, 1'b1, 16'd0);
    wait_pending_clear(cyc);
    tick_gap(gap);
    chk("tick_gap", 32'(gap), 32'd2);
    tag = "load1";
    drive(1'b1, 1'b1, 16'd1);
    wait_pending_clear(cyc);
    tick_gap(gap);
    chk("tick_gap", 32'(gap), 32'd2);

    // ---- back-to-back loads: last wins ----
    tag = "load7_3";
    drive(1'b1, 1'b0, '0);
    drive(1'b1, 1'b1, 16'd7);
    drive(1'b1, 1'b1, 16'd3);
    wait_pending_clear(cyc);
    tick_gap(gap);
    chk("tick_gap", 32'(gap), 32'd3);

    // ---- disable with pending ratio ----
    tag = "disable";
    drive(1'b0, 1'b1, 16'd20);
    chk("direct_pend", 32'(div_pending), 32'd0);
    run(4);
    drive(1'b1, 1'b1, 16'd8);
    run(5);
    drive(1'b0, 1'b0, '0);
    chk("clkout_low", 32'(clkout), 32'd0);
    chk("pend_clear", 32'(div_pending), 32'd0);
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, '0);
      if (clkout) highs++;
    end
    chk("high_in_8", 32'(highs), 32'd4);
    tick_gap(gap);
    chk("tick_gap", 32'(gap), 32'd8);

    // ---- randomized traffic ----
    tag = "random";
    for (int i = 0; i < 3000; i++) begin
      logic en, ld;
      logic [W-1:0] v;
      en = ($urandom_range(0, 19) != 0);
      ld = ($urandom_range(0, 9) == 0);
      v  = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 60)) : W'($urandom_range(0, 9));
      drive(en, ld, v);
    end

    // ---- async reset mid-high-phase ----
    apply_reset();
    tag = "async_reset";
    run(2990);
    drive(1'b1, 1'b1, 16'd9);
    run(9);
    chk("high_before", 32'(clkout), 32'd1);
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    chk("clkout_async", 32'(clkout), 32'd0);
    chk("pend_async", 32'(div_pending), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    ticks = 0;
    for (int i = 0; i < 3 * 4096; i++) begin
      drive(1'b1, 1'b0, '0);
      if (tick) ticks++;
    end
    chk("ticks_after", 32'(ticks), 32'd3);
`ifdef CLKDIV_PERIOD_CNT_EN
    drive(1'b1, 1'b0, '0);
    chk("period_cnt3", period_cnt, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
